// File: rtl/l1_fmap_pkg.sv
// Shared constants and types for the layer-2 feature-map window generator.
// Build option: L1_FMAP_ZERO_PAD_EN selects 'same' padding (centred windows, zero fill outside the map).
package l1_fmap_pkg;

    localparam int DW    = 8;
    localparam int MAP_W = 14;
    localparam int K     = 3;
    localparam int CH    = 6;

`ifdef L1_FMAP_ZERO_PAD_EN
    localparam int PAD   = (K - 1) / 2;
    localparam int OUT_W = MAP_W;
`else
    localparam int OUT_W = MAP_W - K + 1;
`endif

    localparam int PIX_N = MAP_W * MAP_W;
    localparam int PIX_W = $clog2(PIX_N);
    localparam int CH_W  = 3;
    localparam int POS_W = 4;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/l1_fmap_window_gen_fmap_bank.sv
// One channel of the captured map: single write port, K*K combinational window taps.
// With L1_FMAP_ZERO_PAD_EN the taps are centred on (row,col) and out-of-map taps read 0.
module fmap_bank
    import l1_fmap_pkg::*;
(
    input  logic               clk,
    input  logic               i_we,
    input  logic [PIX_W-1:0]   i_waddr,
    input  logic [DW-1:0]      i_wdata,
    input  logic [POS_W-1:0]   i_row,
    input  logic [POS_W-1:0]   i_col,
    output logic [K*K*DW-1:0]  o_taps
);

    logic [DW-1:0] r_mem [PIX_N];

    // Storage is deliberately not reset; a new frame overwrites every entry.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_taps = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin : g_tap
                int w_pr;
                int w_pc;
`ifdef L1_FMAP_ZERO_PAD_EN
                w_pr = int'(i_row) + r - PAD;
                w_pc = int'(i_col) + c - PAD;
                if ((w_pr >= 0) && (w_pr < MAP_W) && (w_pc >= 0) && (w_pc < MAP_W)) begin
                    o_taps[(r*K + c)*DW +: DW] = r_mem[PIX_W'(w_pr*MAP_W + w_pc)];
                end
`else
                w_pr = int'(i_row) + r;
                w_pc = int'(i_col) + c;
                o_taps[(r*K + c)*DW +: DW] = r_mem[PIX_W'(w_pr*MAP_W + w_pc)];
`endif
            end
        end
    end

endmodule

// File: rtl/l1_fmap_window_gen.sv
// Captures a 14x14x6 frame, then replays it as 3x3 windows, one channel per beat, over valid/ready.
// Build option: L1_FMAP_ZERO_PAD_EN (see l1_fmap_pkg) switches to centred, zero-padded windows.
//
// state | meaning
// FILL  | accepting pixels from layer 1 into the banks
// EMIT  | replaying windows; input is refused and flagged as overrun
module l1_fmap_window_gen
    import l1_fmap_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CH*DW-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K*K*DW-1:0]    out_win,
    output logic [CH_W-1:0]      out_ch,
    output logic [POS_W-1:0]     out_row,
    output logic [POS_W-1:0]     out_col,
    output logic                 out_last,
    output logic                 frame_done,
    output logic                 overrun
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PIX_W-1:0]   r_wr_idx;
    logic [POS_W-1:0]   r_row;
    logic [POS_W-1:0]   r_col;
    logic [CH_W-1:0]    r_ch;
    logic               r_started;
    logic               r_seq_done;

    logic               w_wr_en;
    logic               w_wr_last;
    logic               w_load;
    logic               w_accept;
    logic               w_frame_end;
    logic               w_seq_last;
    logic [K*K*DW-1:0]  w_taps [CH];
    logic [K*K*DW-1:0]  w_win_sel;

    assign in_ready    = (r_state == FILL);
    assign w_wr_en     = rst_n && in_valid && (r_state == FILL);
    assign w_wr_last   = w_wr_en && (r_wr_idx == PIX_W'(PIX_N - 1));
    assign w_accept    = out_valid && out_ready;
    assign w_frame_end = w_accept && out_last;
    assign w_seq_last  = (r_row == POS_W'(OUT_W - 1)) && (r_col == POS_W'(OUT_W - 1))
                      && (r_ch == CH_W'(CH - 1));
    // r_started adds one settle cycle after FILL->EMIT before the first window loads.
    assign w_load      = (r_state == EMIT) && r_started && !r_seq_done && (!out_valid || out_ready);

    for (genvar g = 0; g < CH; g++) begin : g_bank
        fmap_bank u_bank (
            .clk     (clk),
            .i_we    (w_wr_en),
            .i_waddr (r_wr_idx),
            .i_wdata (in_data[g*DW +: DW]),
            .i_row   (r_row),
            .i_col   (r_col),
            .o_taps  (w_taps[g])
        );
    end

    always_comb begin
        w_win_sel = '0;
        for (int c = 0; c < CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_win_sel = w_taps[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_wr_last)   w_state_nxt = EMIT;
            EMIT:    if (w_frame_end) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_idx   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_ch       <= '0;
            r_started  <= 1'b0;
            r_seq_done <= 1'b0;
            out_valid  <= 1'b0;
            out_win    <= '0;
            out_ch     <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end

            if (w_wr_en) begin
                r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
            end

            if ((r_state == EMIT) && !r_started) begin
                r_started <= 1'b1;
            end

            if (w_load) begin
                out_valid <= 1'b1;
                out_win   <= w_win_sel;
                out_ch    <= r_ch;
                out_row   <= r_row;
                out_col   <= r_col;
                out_last  <= w_seq_last;
                if (w_seq_last) begin
                    r_seq_done <= 1'b1;
                end
                if (r_ch == CH_W'(CH - 1)) begin
                    r_ch <= '0;
                    if (r_col == POS_W'(OUT_W - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end else if (w_accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (w_frame_end) begin
                frame_done <= 1'b1;
                r_started  <= 1'b0;
                r_seq_done <= 1'b0;
                r_row      <= '0;
                r_col      <= '0;
                r_ch       <= '0;
            end
        end
    end

endmodule
